controller: RTL and testbench

Main control unit of the pipelined MIPS core, in the decode stage. Decodes the 6-bit instruction opcode into datapath control signals (register destination, ALU operand/operation, memory access, write-back source, jump/branch) and registers them into the ID/EX pipeline boundary. Unsupported opcodes decode to a bubble (all controls zero).

---
 rtl/controller_pkg.sv | 61 ++++++
 rtl/controller_decode.sv | 64 ++++++
 rtl/controller.sv | 51 +++++
 tb/tb_controller.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - opcode, ALUOp and write-back encodings shared by the MIPS main controller.
package controller_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ADDIU  = 6'h09;
  localparam logic [5:0] SLTI   = 6'h0A;
  localparam logic [5:0] SLTIU  = 6'h0B;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] LBU    = 6'h24;
  localparam logic [5:0] LHU    = 6'h25;
  localparam logic [5:0] SB     = 6'h28;
  localparam logic [5:0] SH     = 6'h29;
  localparam logic [5:0] SW     = 6'h2B;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_FUNC = 3'b010,
    ALU_SLT  = 3'b011,
    ALU_SLTU = 3'b100,
    ALU_AND  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_XOR  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    REGDST_RT = 2'b00,
    REGDST_RD = 2'b01,
    REGDST_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    WBSRC_MEM  = 2'b00,
    WBSRC_LINK = 2'b01,
    WBSRC_LUI  = 2'b10
  } wb_src_e;

  typedef struct packed {
    reg_dst_e reg_dst;
    logic     alu_src;
    logic     mem_to_reg;
    logic     reg_write;
    wb_src_e  reg_write_src;
    logic     mem_read;
    logic     mem_write;
    logic     jump;
    logic     branch_beq;
    logic     branch_bne;
    alu_op_e  alu_op;
  } ctrl_t;

endpackage

// File: rtl/controller_decode.sv
// rtl/controller_decode.sv - combinational opcode to control-word decode; unknown opcodes give a bubble.
module controller_decode
  import controller_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      R_TYPE: begin
        ctrl.reg_dst   = REGDST_RD;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNC;
      end
      J: ctrl.jump = 1'b1;
      JAL: begin
        ctrl.jump          = 1'b1;
        ctrl.reg_write     = 1'b1;
        ctrl.reg_dst       = REGDST_RA;
        ctrl.reg_write_src = WBSRC_LINK;
      end
      BEQ: begin
        ctrl.branch_beq = 1'b1;
        ctrl.alu_op     = ALU_SUB;
      end
      BNE: begin
        ctrl.branch_bne = 1'b1;
        ctrl.alu_op     = ALU_SUB;
      end
      ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (opcode)
          SLTI:    ctrl.alu_op = ALU_SLT;
          SLTIU:   ctrl.alu_op = ALU_SLTU;
          ANDI:    ctrl.alu_op = ALU_AND;
          ORI:     ctrl.alu_op = ALU_OR;
          XORI:    ctrl.alu_op = ALU_XOR;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      // lui still routes the immediate through operand B; write-back picks {imm,16'h0}
      LUI: begin
        ctrl.reg_write     = 1'b1;
        ctrl.reg_write_src = WBSRC_LUI;
        ctrl.alu_src       = 1'b1;
      end
      LW, LBU, LHU: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      SB, SH, SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// rtl/controller.sv - MIPS main controller: opcode decode registered into the ID/EX boundary.
module controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] RegWriteSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Jump,
  output logic       BranchBEQ,
  output logic       BranchBNE,
  output logic [2:0] ALUOp
);

  ctrl_t dec_ctrl;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  controller_decode u_decode (
    .opcode (opcode),
    .ctrl   (dec_ctrl)
  );

  always_comb begin
    ctrl_d = dec_ctrl;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign RegDst      = ctrl_q.reg_dst;
  assign ALUSrc      = ctrl_q.alu_src;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign RegWrite    = ctrl_q.reg_write;
  assign RegWriteSrc = ctrl_q.reg_write_src;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign Jump        = ctrl_q.jump;
  assign BranchBEQ   = ctrl_q.branch_beq;
  assign BranchBNE   = ctrl_q.branch_bne;
  assign ALUOp       = ctrl_q.alu_op;

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - directed and random-invariant bench for the MIPS main controller.
`timescale 1ns/100ps
module tb_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [1:0] RegDst;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic [1:0] RegWriteSrc;
  logic       MemRead;
  logic       MemWrite;
  logic       Jump;
  logic       BranchBEQ;
  logic       BranchBNE;
  logic [2:0] ALUOp;

  int n_checks = 0;
  int n_pass   = 0;

  logic [14:0] obs;

  typedef struct {
    logic [5:0]  op;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #7.5 clk = ~clk;

  controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .RegDst      (RegDst),
    .ALUSrc      (ALUSrc),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .RegWriteSrc (RegWriteSrc),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Jump        (Jump),
    .BranchBEQ   (BranchBEQ),
    .BranchBNE   (BranchBNE),
    .ALUOp       (ALUOp)
  );

  assign obs = {RegDst, ALUSrc, MemtoReg, RegWrite, RegWriteSrc,
                MemRead, MemWrite, Jump, BranchBEQ, BranchBNE, ALUOp};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [14:0] mk(input logic [1:0] rd, input logic as, input logic m2r,
                                     input logic rw, input logic [1:0] rws, input logic mr,
                                     input logic mw, input logic j, input logic beq,
                                     input logic bne, input logic [2:0] op);
    return {rd, as, m2r, rw, rws, mr, mw, j, beq, bne, op};
  endfunction

  task automatic add(input logic [5:0] op, input logic [14:0] exp);
    vec_t v;
    v.op  = op;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic [5:0] op, input logic [14:0] exp);
    @(negedge clk);
    opcode = op;
    @(posedge clk);
    #1;
    check($sformatf("op_%02h", op), {17'd0, obs}, {17'd0, exp});
  endtask

  initial begin
    //   op      rd     as m2r rw rws  mr mw j beq bne alu
    add(6'h00, mk(2'b01, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b010));
    add(6'h02, mk(2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 3'b000));
    add(6'h03, mk(2'b10, 0, 0, 1, 2'b01, 0, 0, 1, 0, 0, 3'b000));
    add(6'h04, mk(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 3'b001));
    add(6'h05, mk(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3'b001));
    add(6'h08, mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b000));
    add(6'h09, mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b000));
    add(6'h0A, mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b011));
    add(6'h0B, mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b100));
    add(6'h0C, mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b101));
    add(6'h0D, mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b110));
    add(6'h0E, mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b111));
    add(6'h0F, mk(2'b00, 1, 0, 1, 2'b10, 0, 0, 0, 0, 0, 3'b000));
    add(6'h23, mk(2'b00, 1, 1, 1, 2'b00, 1, 0, 0, 0, 0, 3'b000));
    add(6'h24, mk(2'b00, 1, 1, 1, 2'b00, 1, 0, 0, 0, 0, 3'b000));
    add(6'h25, mk(2'b00, 1, 1, 1, 2'b00, 1, 0, 0, 0, 0, 3'b000));
    add(6'h28, mk(2'b00, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 3'b000));
    add(6'h29, mk(2'b00, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 3'b000));
    add(6'h2B, mk(2'b00, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 3'b000));
    add(6'h06, 15'd0);
    add(6'h20, 15'd0);
    add(6'h3F, 15'd0);

    // reset held for two edges with lw present, then released
    rst_n  = 1'b0;
    opcode = 6'h23;
    @(posedge clk); #1;
    check("rst_edge1", {17'd0, obs}, 32'd0);
    @(posedge clk); #1;
    check("rst_edge2", {17'd0, obs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_lw", {17'd0, obs},
          {17'd0, mk(2'b00, 1, 1, 1, 2'b00, 1, 0, 0, 0, 0, 3'b000)});

    foreach (vecs[i]) apply(vecs[i].op, vecs[i].exp);

    // back-to-back branches, then a store followed by reset asserted mid-stream
    apply(6'h04, mk(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 3'b001));
    apply(6'h05, mk(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3'b001));
    apply(6'h03, mk(2'b10, 0, 0, 1, 2'b01, 0, 0, 1, 0, 0, 3'b000));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_midstream", {17'd0, obs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_jal", {17'd0, obs},
          {17'd0, mk(2'b10, 0, 0, 1, 2'b01, 0, 0, 1, 0, 0, 3'b000)});

    for (int c = 0; c < 1000; c++) begin
      logic rst_now;
      @(negedge clk);
      opcode  = 6'($urandom_range(0, 63));
      rst_now = ($urandom_range(0, 3) != 0);
      rst_n   = rst_now;
      @(posedge clk); #1;
      check("inv_mem_rw", {31'd0, MemRead & MemWrite}, 32'd0);
      check("inv_one_flow", {31'd0, (32'(Jump) + 32'(BranchBEQ) + 32'(BranchBNE)) > 1}, 32'd0);
      check("inv_m2r_read", {31'd0, MemtoReg & ~MemRead}, 32'd0);
      if (!rst_now) check("rand_rst_zero", {17'd0, obs}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
